div_seq_controller: RTL and testbench

Parametrised sequencing controller for the shift-subtract (restoring) divider datapath. Accepts a start pulse, loads operands, then runs WIDTH subtract/decide iterations. Each iteration is steered by the sign of the trial remainder. Signals completion with a one-cycle valid. Sits between the system start/result handshake and the divider's register/ALU/mux datapath; replaces the fixed-width controller with a width-generic version that adds a busy output and optional divide-by-zero handling.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_iter_counter.sv | 36 +++
 rtl/div_seq_controller.sv | 122 ++++++++++++
 tb/tb_div_seq_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and datapath mux selects for the divider controller
package div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        SUB  = 3'b010,
        RST  = 3'b011,
        SHF  = 3'b100,
        DONE = 3'b101
    } div_state_e;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_ALU   = 2'b01;
    localparam logic [1:0] SEL_LOAD  = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

endpackage

// File: rtl/div_iter_counter.sv
// rtl/div_iter_counter.sv - iteration counter for the divider; saturates at WIDTH-1
module div_iter_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // clear wins over inc; the last check keeps the count from ever wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_seq_controller.sv
// rtl/div_seq_controller.sv - Moore sequencer for the restoring divider datapath
// DIVCTL_DBZ_EN adds dbz input and dbz_err output for divide-by-zero early exit.
module div_seq_controller
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sign,
`ifdef DIVCTL_DBZ_EN
    input  logic       dbz,
    output logic       dbz_err,
`endif
    output logic       load,
    output logic       add,
    output logic       shift,
    output logic       inbit,
    output logic [1:0] sel,
    output logic       valid,
    output logic       busy
);

    div_state_e state_q, state_d;
    logic       last;
    logic       cnt_clear;
    logic       cnt_inc;

    assign cnt_clear = start || (state_q == LOAD);
    assign cnt_inc   = !start && ((state_q == RST) || (state_q == SHF));

    div_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (last)
    );

`ifdef DIVCTL_DBZ_EN
    logic dbz_q, dbz_d;

    assign dbz_d   = (state_q == LOAD) ? dbz : dbz_q;
    assign dbz_err = (state_q == DONE) && dbz_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
`ifdef DIVCTL_DBZ_EN
            LOAD:    state_d = dbz ? DONE : SUB;
`else
            LOAD:    state_d = SUB;
`endif
            SUB:     state_d = sign ? RST : SHF;
            RST,
            SHF:     state_d = last ? DONE : SUB;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a new start aborts whatever is running, including a pending DONE
        if (start) begin
            state_d = LOAD;
        end
    end

    always_comb begin
        load  = 1'b0;
        add   = 1'b0;
        shift = 1'b0;
        inbit = 1'b0;
        sel   = SEL_HOLD;
        valid = 1'b0;
        busy  = 1'b0;
        case (state_q)
            LOAD: begin
                load = 1'b1;
                sel  = SEL_LOAD;
                busy = 1'b1;
            end
            SUB: begin
                sel  = SEL_ALU;
                busy = 1'b1;
            end
            RST: begin
                sel   = SEL_ALU;
                add   = 1'b1;
                shift = 1'b1;
                busy  = 1'b1;
            end
            SHF: begin
                sel   = SEL_SHIFT;
                shift = 1'b1;
                inbit = 1'b1;
                busy  = 1'b1;
            end
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_seq_controller.sv
// tb/tb_div_seq_controller.sv - randomized scoreboard bench for div_seq_controller (WIDTH 8 and 16)
module tb_div_seq_controller;

    logic clk = 1'b0;
    logic reset;
    logic start_a = 1'b0, sign_a = 1'b0, start_b = 1'b0, sign_b = 1'b0;
    logic load_a, add_a, shift_a, inbit_a, valid_a, busy_a;
    logic load_b, add_b, shift_b, inbit_b, valid_b, busy_b;
    logic [1:0] sel_a, sel_b;
`ifdef DIVCTL_DBZ_EN
    logic dbz_a = 1'b0, dbz_b = 1'b0, dbz_err_a, dbz_err_b;
`endif

    always #5 clk = ~clk;

    div_seq_controller #(.WIDTH(8)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sign(sign_a),
`ifdef DIVCTL_DBZ_EN
        .dbz(dbz_a), .dbz_err(dbz_err_a),
`endif
        .load(load_a), .add(add_a), .shift(shift_a), .inbit(inbit_a),
        .sel(sel_a), .valid(valid_a), .busy(busy_a)
    );

    div_seq_controller #(.WIDTH(16)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sign(sign_b),
`ifdef DIVCTL_DBZ_EN
        .dbz(dbz_b), .dbz_err(dbz_err_b),
`endif
        .load(load_b), .add(add_b), .shift(shift_b), .inbit(inbit_b),
        .sel(sel_b), .valid(valid_b), .busy(busy_b)
    );

    // expected output vector {load,add,shift,inbit,sel,valid,busy,dbz_err}
    localparam logic [8:0] V_LOAD  = 9'b1_0_0_0_10_0_1_0;
    localparam logic [8:0] V_SUB   = 9'b0_0_0_0_01_0_1_0;
    localparam logic [8:0] V_RST   = 9'b0_1_1_0_01_0_1_0;
    localparam logic [8:0] V_SHF   = 9'b0_0_1_1_11_0_1_0;
    localparam logic [8:0] V_DONE  = 9'b0_0_0_0_00_1_0_0;
    localparam logic [8:0] V_DONEZ = 9'b0_0_0_0_00_1_0_1;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic [8:0] exp_tr [int];
    bit         sign_at [int];
    bit         dbz_at [int];
    int         vq [$];

    function automatic int key(int inst, int c);
        return inst * 1000000 + c;
    endfunction

    function automatic logic [8:0] vec(int inst);
        logic e;
        e = 1'b0;
`ifdef DIVCTL_DBZ_EN
        e = (inst == 0) ? dbz_err_a : dbz_err_b;
`endif
        if (inst == 0) return {load_a, add_a, shift_a, inbit_a, sel_a, valid_a, busy_a, e};
        return {load_b, add_b, shift_b, inbit_b, sel_b, valid_b, busy_b, e};
    endfunction

    task automatic check(string name, int c, logic [8:0] act, logic [8:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, c, act, want);
        end
    endtask

    task automatic purge(int inst, int from);
        int ks[$];
        int nq[$];
        foreach (exp_tr[kk]) if (kk / 1000000 == inst && kk % 1000000 >= from) ks.push_back(kk);
        foreach (ks[j]) exp_tr.delete(ks[j]);
        foreach (vq[j]) if (!(vq[j] / 1000000 == inst && vq[j] % 1000000 >= from)) nq.push_back(vq[j]);
        vq = nq;
    endtask

    // Timeline model: the LOAD cycle L follows the start edge, iteration i
    // occupies cycles L+1+2i (subtract) and L+2+2i (restore or shift).
    task automatic issue(int inst, logic [63:0] pat, bit dbz = 1'b0);
        int w;
        int l;
        w = (inst == 0) ? 8 : 16;
        l = cyc + 1;
        purge(inst, l);
        exp_tr[key(inst, l)] = V_LOAD;
        dbz_at[key(inst, l)] = dbz;
        if (dbz) begin
            exp_tr[key(inst, l + 1)] = V_DONEZ;
            vq.push_back(key(inst, l + 1));
        end else begin
            for (int i = 0; i < w; i++) begin
                exp_tr[key(inst, l + 1 + 2 * i)]  = V_SUB;
                sign_at[key(inst, l + 1 + 2 * i)] = pat[i];
                exp_tr[key(inst, l + 2 + 2 * i)]  = pat[i] ? V_RST : V_SHF;
            end
            exp_tr[key(inst, l + 1 + 2 * w)] = V_DONE;
            vq.push_back(key(inst, l + 1 + 2 * w));
        end
        if (inst == 0) start_a = 1'b1;
        else           start_b = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        sign_a  = sign_at.exists(key(0, cyc)) ? sign_at[key(0, cyc)] : 1'($urandom);
        sign_b  = sign_at.exists(key(1, cyc)) ? sign_at[key(1, cyc)] : 1'($urandom);
`ifdef DIVCTL_DBZ_EN
        dbz_a   = dbz_at.exists(key(0, cyc)) ? dbz_at[key(0, cyc)] : 1'($urandom);
        dbz_b   = dbz_at.exists(key(1, cyc)) ? dbz_at[key(1, cyc)] : 1'($urandom);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_tr.delete();
        vq.delete();
        #1;
        check("async_reset_w8", cyc, vec(0), 9'd0);
        check("async_reset_w16", cyc, vec(1), 9'd0);
    endtask

    task automatic valid_pop(int inst);
        int idx;
        idx = -1;
        foreach (vq[j]) if (idx < 0 && vq[j] == key(inst, cyc)) idx = j;
        total++;
        if (idx >= 0) begin
            vq.delete(idx);
        end else begin
            bad++;
            $display("FAIL valid_sb inst=%0d cycle=%0d got=unexpected valid want=none", inst, cyc);
        end
    endtask

    always @(negedge clk) begin
        check("trace_w8", cyc, vec(0), exp_tr.exists(key(0, cyc)) ? exp_tr[key(0, cyc)] : 9'd0);
        check("trace_w16", cyc, vec(1), exp_tr.exists(key(1, cyc)) ? exp_tr[key(1, cyc)] : 9'd0);
        if (valid_a) valid_pop(0);
        if (valid_b) valid_pop(1);
    end

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset_w8", cyc, vec(0), 9'd0);
        check("reset_w16", cyc, vec(1), 9'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();

        issue(0, 64'h0);
        repeat (20) tick();
        issue(0, '1);
        repeat (20) tick();
        issue(0, 64'h69);
        repeat (20) tick();
        issue(1, {$urandom, $urandom});
        repeat (36) tick();

        // abort during the subtract of iteration 3
        issue(0, {$urandom, $urandom});
        repeat (8) tick();
        issue(0, {$urandom, $urandom});
        repeat (20) tick();

        // restart while DONE is showing
        issue(0, {$urandom, $urandom});
        repeat (18) tick();
        issue(0, {$urandom, $urandom});
        repeat (20) tick();

        repeat (5) begin
            issue(0, {$urandom, $urandom});
            tick();
        end
        repeat (20) tick();

        // async reset during iteration 5
        issue(0, {$urandom, $urandom});
        issue(1, {$urandom, $urandom});
        repeat (12) tick();
        do_reset();
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();

        repeat (10) begin
            issue(0, {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) issue(1, {$urandom, $urandom});
            repeat ($urandom_range(3, 22)) tick();
        end
        repeat (40) tick();

`ifdef DIVCTL_DBZ_EN
        issue(0, {$urandom, $urandom}, 1'b1);
        issue(1, {$urandom, $urandom}, 1'b1);
        repeat (5) tick();
        issue(0, {$urandom, $urandom}, 1'b0);
        repeat (20) tick();
`endif

        total++;
        if (vq.size() != 0) begin
            bad++;
            $display("FAIL valid_missing got=%0d outstanding want=0", vq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
